// File: rtl/huff_tree_merge_if.sv
// huff_tree_merge_if: start/list/table-read/result bundle between the tree merger and its driver
interface huff_tree_merge_if;
    logic        merge_begin;
    logic [12:0] node1, node2, node3, node4, node5, node6;
    logic [3:0]  rd_addr;
    logic [4:0]  rd_parent;
    logic        rd_bit;
    logic        busy;
    logic        merge_over;
    logic [4:0]  root_id;
    logic [7:0]  root_weight;
    modport master (
        output merge_begin, node1, node2, node3, node4, node5, node6, rd_addr,
        input  rd_parent, rd_bit, busy, merge_over, root_id, root_weight
    );
    modport slave (
        input  merge_begin, node1, node2, node3, node4, node5, node6, rd_addr,
        output rd_parent, rd_bit, busy, merge_over, root_id, root_weight
    );
endinterface

// File: rtl/huff_tree_merge.sv
// huff_tree_merge: merges a sorted six-node list into a Huffman tree and records a parent/branch-bit table.
// Define HUFF_SAT_EN to saturate weight sums at 8'hFF; otherwise sums wrap modulo 256.
module huff_tree_merge (
    input logic CLK,
    input logic RST,
    huff_tree_merge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MERGE, INSERT, DONE} state_t;
    state_t      state, state_nxt;
    logic [12:0] lst [0:5];
    logic [12:0] ins [0:5];
    logic [12:0] n_node;
    logic [2:0]  cnt, pos;
    logic [4:0]  next_id;
    logic [5:0]  tbl [0:10];
    logic [5:0]  rd_sel;
    logic [8:0]  wide;
    logic [7:0]  sum;
    logic        start, over_q;
    logic [4:0]  root_id_q;
    logic [7:0]  root_w_q;
    assign start = (state == IDLE || state == DONE) && bus.merge_begin;
    assign wide  = {1'b0, lst[0][12:5]} + {1'b0, lst[1][12:5]};
`ifdef HUFF_SAT_EN
    assign sum = wide[8] ? 8'hFF : wide[7:0];
`else
    assign sum = wide[7:0];
`endif
    always_comb begin
        state_nxt = start ? MERGE
                  : state == MERGE ? INSERT
                  : state == INSERT ? (cnt == 3'd0 ? DONE : MERGE)
                  : state;
    end
    // New node goes ahead of the first entry that is at least as heavy
    always_comb begin
        pos = cnt;
        for (int i = 5; i >= 0; i--)
            if (3'(i) < cnt && lst[i][12:5] >= n_node[12:5]) pos = 3'(i);
        ins[0] = pos == 3'd0 ? n_node : lst[0];
        for (int i = 1; i < 6; i++)
            ins[i] = 3'(i) < pos ? lst[i] : 3'(i) == pos ? n_node : lst[i-1];
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            next_id   <= '0;
            n_node    <= '0;
            over_q    <= 1'b0;
            root_id_q <= '0;
            root_w_q  <= '0;
            for (int i = 0; i < 6; i++) lst[i] <= '0;
            for (int i = 0; i < 11; i++) tbl[i] <= 6'h3E;
        end else begin
            state <= state_nxt;
            if (start) begin
                lst[0]  <= bus.node1;
                lst[1]  <= bus.node2;
                lst[2]  <= bus.node3;
                lst[3]  <= bus.node4;
                lst[4]  <= bus.node5;
                lst[5]  <= bus.node6;
                cnt     <= 3'd6;
                next_id <= 5'd6;
                over_q  <= 1'b0;
            end else if (state == MERGE) begin
                n_node <= {sum, next_id};
                for (int i = 0; i < 4; i++) lst[i] <= lst[i+2];
                lst[4] <= '0;
                lst[5] <= '0;
                if (lst[0][4:0] <= 5'd10) tbl[lst[0][3:0]] <= {next_id, 1'b0};
                if (lst[1][4:0] <= 5'd10) tbl[lst[1][3:0]] <= {next_id, 1'b1};
                cnt <= cnt - 3'd2;
            end else if (state == INSERT) begin
                for (int i = 0; i < 6; i++) lst[i] <= ins[i];
                cnt     <= cnt + 3'd1;
                next_id <= next_id + 5'd1;
                if (cnt == 3'd0) begin
                    over_q    <= 1'b1;
                    root_id_q <= n_node[4:0];
                    root_w_q  <= n_node[12:5];
                end
            end
        end
    end
    assign rd_sel          = bus.rd_addr <= 4'd10 ? tbl[bus.rd_addr] : 6'h3E;
    assign bus.rd_parent   = rd_sel[5:1];
    assign bus.rd_bit      = rd_sel[0];
    assign bus.busy        = state == MERGE || state == INSERT;
    assign bus.merge_over  = over_q;
    assign bus.root_id     = root_id_q;
    assign bus.root_weight = root_w_q;
endmodule
